// File: rtl/tl_ul_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_chk_pkg
// Purpose  : Shared TileLink-UL opcode constants, error-bit positions and the
//            A-to-D expected-opcode helper for the in-flight checker.
// Revision : 1.0 - initial release
// ============================================================================
package tl_ul_chk_pkg;

  // A-channel opcodes accepted by the checker
  localparam logic [2:0] c_A_PUT_FULL    = 3'd0;
  localparam logic [2:0] c_A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] c_A_GET         = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] c_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] c_D_ACCESS_ACK_DATA = 3'd1;

  // Bit positions inside the error vector and err_sticky
  localparam int c_ERR_W         = 6;
  localparam int c_ERR_DUP       = 0;
  localparam int c_ERR_ORPHAN    = 1;
  localparam int c_ERR_OPCODE    = 2;
  localparam int c_ERR_SIZE      = 3;
  localparam int c_ERR_TIMEOUT   = 4;
  localparam int c_ERR_ILLEGAL_A = 5;

  // True for the three A opcodes that TL-UL allows
  function automatic logic a_opcode_legal(input logic [2:0] op);
    return (op == c_A_PUT_FULL) || (op == c_A_PUT_PARTIAL) || (op == c_A_GET);
  endfunction

  // Get expects data back; both Put flavours expect a plain ack
  function automatic logic [2:0] exp_d_opcode(input logic [2:0] a_op);
    return (a_op == c_A_GET) ? c_D_ACCESS_ACK_DATA : c_D_ACCESS_ACK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_ul_inflight_entry.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_inflight_entry
// Purpose  : One per-source tracking slot: holds the outstanding request,
//            ages it, and compares the matching D response against it.
// Revision : 1.0 - initial release
// ============================================================================
module tl_ul_inflight_entry #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_hit_i,      // legal A fire on this source
  input  logic [2:0] a_exp_op_i,   // D opcode the new request expects
  input  logic [2:0] a_size_i,
  input  logic       d_hit_i,      // D fire on this source
  input  logic [2:0] d_opcode_i,
  input  logic [2:0] d_size_i,
  output logic       valid_d_o,    // next-state valid, used for the registered count
  output logic       dup_o,
  output logic       orphan_o,
  output logic       op_err_o,
  output logic       size_err_o,
  output logic       timeout_o
);

  localparam int c_AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [c_AGE_W-1:0] c_AGE_MAX  = c_AGE_W'(TIMEOUT);
  localparam logic [c_AGE_W-1:0] c_AGE_LAST = c_AGE_W'(TIMEOUT - 1);

  logic               valid_q, valid_d;
  logic [2:0]         op_q, op_d;
  logic [2:0]         size_q, size_d;
  logic [c_AGE_W-1:0] age_q, age_d;
  logic               to_q, to_d;

  // The timeout event is judged on the registered age only, so a response in
  // the very cycle the deadline is reached still sees the timeout raised.
  assign timeout_o  = valid_q && !to_q && (age_q == c_AGE_LAST);
  assign orphan_o   = d_hit_i && !valid_q;
  assign op_err_o   = d_hit_i && valid_q && (d_opcode_i != op_q);
  assign size_err_o = d_hit_i && valid_q && (d_size_i != size_q);
  // A same-cycle response retires the old entry first, so that is not a dup
  assign dup_o      = a_hit_i && valid_q && !d_hit_i;
  assign valid_d_o  = valid_d;

  // Next state: allocation wins over retirement, otherwise age the entry
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    size_d  = size_q;
    age_d   = age_q;
    to_d    = to_q;
    if (a_hit_i) begin
      valid_d = 1'b1;
      op_d    = a_exp_op_i;
      size_d  = a_size_i;
      age_d   = '0;
      to_d    = 1'b0;
    end else if (d_hit_i) begin
      valid_d = 1'b0;
      age_d   = '0;
      to_d    = 1'b0;
    end else if (valid_q) begin
      if (age_q != c_AGE_MAX) age_d = age_q + c_AGE_W'(1);
      if (timeout_o) to_d = 1'b1;
    end
  end

  // Entry state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      size_q  <= '0;
      age_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      size_q  <= size_d;
      age_q   <= age_d;
      to_q    <= to_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tl_ul_inflight_checker.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_inflight_checker
// Purpose  : Passive TL-UL A/D pairing checker; tracks one outstanding request
//            per source and reports dup/orphan/opcode/size/timeout/illegal-A.
// Revision : 1.0 - initial release
// ============================================================================
module tl_ul_inflight_checker
  import tl_ul_chk_pkg::*;
#(
  parameter int SOURCE_W = 4,
  parameter int SIZE_MAX = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                a_valid_i,
  input  logic                a_ready_i,
  input  logic [2:0]          a_opcode_i,
  input  logic [2:0]          a_size_i,
  input  logic [SOURCE_W-1:0] a_source_i,
  input  logic                d_valid_i,
  input  logic                d_ready_i,
  input  logic [2:0]          d_opcode_i,
  input  logic [2:0]          d_size_i,
  input  logic [SOURCE_W-1:0] d_source_i,
  output logic [SOURCE_W:0]   inflight_count_o,
  output logic                err_dup_o,
  output logic                err_orphan_o,
  output logic                err_opcode_o,
  output logic                err_size_o,
  output logic                err_timeout_o,
  output logic                err_illegal_a_o,
  output logic [5:0]          err_sticky_o,
  output logic [SOURCE_W-1:0] first_err_source_o,
  output logic                first_err_valid_o
);

  localparam int         c_N        = 2 ** SOURCE_W;
  localparam logic [2:0] c_SIZE_MAX = 3'(SIZE_MAX);

  logic                w_a_fire, w_d_fire, w_a_legal;
  logic [c_N-1:0]      w_a_hit, w_d_hit, w_valid_d;
  logic [c_N-1:0]      w_dup, w_orphan, w_op_err, w_size_err, w_timeout;
  logic [c_ERR_W-1:0]  w_err;
  logic                w_d_side, w_a_side;
  logic [SOURCE_W-1:0] w_to_src, w_err_src;
  logic [SOURCE_W:0]   w_count_d;

  logic [c_ERR_W-1:0]  err_q, sticky_q;
  logic [SOURCE_W:0]   count_q;
  logic                fev_q;
  logic [SOURCE_W-1:0] fsrc_q;

  assign w_a_fire  = a_valid_i && a_ready_i;
  assign w_d_fire  = d_valid_i && d_ready_i;
  assign w_a_legal = a_opcode_legal(a_opcode_i) && (a_size_i <= c_SIZE_MAX);

  generate
    for (genvar gi = 0; gi < c_N; gi++) begin : g_entry
      assign w_a_hit[gi] = w_a_fire && w_a_legal && (a_source_i == SOURCE_W'(gi));
      assign w_d_hit[gi] = w_d_fire && (d_source_i == SOURCE_W'(gi));

      tl_ul_inflight_entry #(
        .TIMEOUT (TIMEOUT)
      ) u_entry (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .a_hit_i    (w_a_hit[gi]),
        .a_exp_op_i (exp_d_opcode(a_opcode_i)),
        .a_size_i   (a_size_i),
        .d_hit_i    (w_d_hit[gi]),
        .d_opcode_i (d_opcode_i),
        .d_size_i   (d_size_i),
        .valid_d_o  (w_valid_d[gi]),
        .dup_o      (w_dup[gi]),
        .orphan_o   (w_orphan[gi]),
        .op_err_o   (w_op_err[gi]),
        .size_err_o (w_size_err[gi]),
        .timeout_o  (w_timeout[gi])
      );
    end
  endgenerate

  // Combine per-entry error strobes into the shared error vector
  always_comb begin
    w_err                  = '0;
    w_err[c_ERR_DUP]       = |w_dup;
    w_err[c_ERR_ORPHAN]    = |w_orphan;
    w_err[c_ERR_OPCODE]    = |w_op_err;
    w_err[c_ERR_SIZE]      = |w_size_err;
    w_err[c_ERR_TIMEOUT]   = |w_timeout;
    w_err[c_ERR_ILLEGAL_A] = w_a_fire && !w_a_legal;
  end

  // Lowest-index timed-out entry; scanning downward lets the lowest win
  always_comb begin
    w_to_src = '0;
    for (int i = c_N - 1; i >= 0; i--) begin
      if (w_timeout[i]) w_to_src = SOURCE_W'(i);
    end
  end

  // First-error source priority: D side, then A side, then timeout
  always_comb begin
    w_d_side  = w_err[c_ERR_ORPHAN] || w_err[c_ERR_OPCODE] || w_err[c_ERR_SIZE];
    w_a_side  = w_err[c_ERR_DUP] || w_err[c_ERR_ILLEGAL_A];
    w_err_src = w_to_src;
    if (w_d_side)      w_err_src = d_source_i;
    else if (w_a_side) w_err_src = a_source_i;
  end

  // Popcount of next-state valids so the registered count tracks last cycle's fires
  always_comb begin
    w_count_d = '0;
    for (int i = 0; i < c_N; i++) begin
      w_count_d = w_count_d + {{SOURCE_W{1'b0}}, w_valid_d[i]};
    end
  end

  // Output registers: pulses, sticky summary, count and first-error capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q    <= '0;
      sticky_q <= '0;
      count_q  <= '0;
      fev_q    <= 1'b0;
      fsrc_q   <= '0;
    end else begin
      err_q    <= w_err;
      sticky_q <= sticky_q | w_err;
      count_q  <= w_count_d;
      if (!fev_q && (|w_err)) begin
        fev_q  <= 1'b1;
        fsrc_q <= w_err_src;
      end
    end
  end

  assign err_dup_o          = err_q[c_ERR_DUP];
  assign err_orphan_o       = err_q[c_ERR_ORPHAN];
  assign err_opcode_o       = err_q[c_ERR_OPCODE];
  assign err_size_o         = err_q[c_ERR_SIZE];
  assign err_timeout_o      = err_q[c_ERR_TIMEOUT];
  assign err_illegal_a_o    = err_q[c_ERR_ILLEGAL_A];
  assign err_sticky_o       = sticky_q;
  assign inflight_count_o   = count_q;
  assign first_err_source_o = fsrc_q;
  assign first_err_valid_o  = fev_q;

endmodule
`default_nettype wire
